// File: rtl/m68k_spi_master_ctrl.sv
// 68k-bus SPI master: control/status/data/divider/select registers, TX/RX byte
// FIFOs, DTACK_L handshake and a mode 0-3, MSB-first shift engine.
module m68k_spi_master_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 8
) (
  input  logic              Clk,
  input  logic              Reset_H,
  input  logic              Enable_H,
  input  logic [2:0]        Address,
  input  logic              WE_L,
  input  logic [7:0]        DataIn,
  output logic [7:0]        DataOut,
  output logic              DTACK_L,
  output logic              IRQ_L,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO,
  output logic [NUM_SS-1:0] SS_L
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_r;
  logic          enable_d_r;
  logic          spie_r, spe_r, cpol_r, cpha_r, spif_r, wcol_r, rovr_r;
  logic [7:0]    div_r;
  logic [7:0]    tx_mem_r [FIFO_DEPTH];
  logic [7:0]    rx_mem_r [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_r, tx_rd_r, rx_wr_r, rx_rd_r;
  logic [CW-1:0] tx_cnt_r, rx_cnt_r;
  logic [7:0]    sh_r, rx_sh_r, div_cnt_r, div_act_r;
  logic [3:0]    edge_r;

  logic       access_s, wr_s, rd_s, stat_wr_s;
  logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic       done_s, wcol_set_s, rovr_set_s;
  logic [7:0] status_s, rdata_s;

  // A new access is the first cycle of an Enable_H pulse; later cycles have no side effect.
  assign access_s   = Enable_H & ~enable_d_r;
  assign wr_s       = access_s & ~WE_L;
  assign rd_s       = access_s & WE_L;
  assign stat_wr_s  = wr_s && (Address == 3'd1);
  assign tx_full_s  = (tx_cnt_r == FULL_CNT);
  assign tx_empty_s = (tx_cnt_r == {CW{1'b0}});
  assign rx_full_s  = (rx_cnt_r == FULL_CNT);
  assign rx_empty_s = (rx_cnt_r == {CW{1'b0}});
  assign tx_pop_s   = (state_r == LOAD);
  assign tx_push_s  = wr_s && (Address == 3'd2) && (!tx_full_s || tx_pop_s);
  assign wcol_set_s = wr_s && (Address == 3'd2) && tx_full_s && !tx_pop_s;
  assign rx_pop_s   = rd_s && (Address == 3'd2) && !rx_empty_s;
  assign done_s     = (state_r == DONE) && spe_r;
  assign rx_push_s  = done_s && (!rx_full_s || rx_pop_s);
  assign rovr_set_s = done_s && rx_full_s && !rx_pop_s;
  assign status_s   = {spif_r, wcol_r, rovr_r, 1'b0, tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};

  // Register read multiplexer.
  always_comb begin
    rdata_s = 8'h00;
    case (Address)
      3'd0:    rdata_s = {spie_r, spe_r, 2'b00, cpol_r, cpha_r, 2'b00};
      3'd1:    rdata_s = status_s;
      3'd2:    rdata_s = rx_empty_s ? 8'h00 : rx_mem_r[rx_rd_r];
      3'd3:    rdata_s = div_r;
      3'd4:    rdata_s = 8'(~SS_L);
      default: rdata_s = 8'h00;
    endcase
  end

  // Bus handshake, control registers and sticky status flags.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      enable_d_r <= 1'b0;
      DTACK_L    <= 1'b1;
      DataOut    <= 8'h00;
      IRQ_L      <= 1'b1;
      spie_r     <= 1'b0;
      spe_r      <= 1'b0;
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      spif_r     <= 1'b0;
      wcol_r     <= 1'b0;
      rovr_r     <= 1'b0;
      div_r      <= 8'h00;
      SS_L       <= {NUM_SS{1'b1}};
    end else begin
      enable_d_r <= Enable_H;
      DTACK_L    <= ~Enable_H;
      IRQ_L      <= ~(spie_r & spif_r);
      if (rd_s) begin
        DataOut <= rdata_s;
      end
      if (wr_s) begin
        case (Address)
          3'd0: begin
            spie_r <= DataIn[7];
            spe_r  <= DataIn[6];
            cpol_r <= DataIn[3];
            cpha_r <= DataIn[2];
          end
          3'd3:    div_r <= DataIn;
          3'd4:    SS_L  <= ~NUM_SS'(DataIn);
          default: ;
        endcase
      end
      // A set in the same cycle as a write-1-to-clear wins.
      spif_r <= done_s     | (spif_r & ~(stat_wr_s & DataIn[7]));
      wcol_r <= wcol_set_s | (wcol_r & ~(stat_wr_s & DataIn[6]));
      rovr_r <= rovr_set_s | (rovr_r & ~(stat_wr_s & DataIn[5]));
    end
  end

  // TX and RX FIFO storage, pointers and occupancy counts.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      tx_wr_r  <= {AW{1'b0}};
      tx_rd_r  <= {AW{1'b0}};
      rx_wr_r  <= {AW{1'b0}};
      rx_rd_r  <= {AW{1'b0}};
      tx_cnt_r <= {CW{1'b0}};
      rx_cnt_r <= {CW{1'b0}};
    end else begin
      if (tx_push_s) begin
        tx_mem_r[tx_wr_r] <= DataIn;
        tx_wr_r           <= tx_wr_r + AW'(1);
      end
      if (tx_pop_s) begin
        tx_rd_r <= tx_rd_r + AW'(1);
      end
      if (rx_push_s) begin
        rx_mem_r[rx_wr_r] <= rx_sh_r;
        rx_wr_r           <= rx_wr_r + AW'(1);
      end
      if (rx_pop_s) begin
        rx_rd_r <= rx_rd_r + AW'(1);
      end
      tx_cnt_r <= tx_cnt_r + CW'(tx_push_s) - CW'(tx_pop_s);
      rx_cnt_r <= rx_cnt_r + CW'(rx_push_s) - CW'(rx_pop_s);
    end
  end

  // Shift engine; edge_r counts completed SCK edges, so edge_r[0]==0 marks an odd edge.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_r   <= IDLE;
      SCK       <= 1'b0;
      MOSI      <= 1'b0;
      sh_r      <= 8'h00;
      rx_sh_r   <= 8'h00;
      div_cnt_r <= 8'h00;
      div_act_r <= 8'h00;
      edge_r    <= 4'd0;
    end else if (!spe_r && (state_r != IDLE)) begin
      state_r <= IDLE;
      SCK     <= cpol_r;
    end else begin
      case (state_r)
        IDLE: begin
          SCK <= cpol_r;
          if (spe_r && !tx_empty_s) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          sh_r      <= tx_mem_r[tx_rd_r];
          SCK       <= cpol_r;
          div_cnt_r <= 8'h00;
          div_act_r <= div_r;
          edge_r    <= 4'd0;
          state_r   <= SHIFT;
          if (!cpha_r) begin
            MOSI <= tx_mem_r[tx_rd_r][7];
          end
        end
        SHIFT: begin
          if (div_cnt_r == div_act_r) begin
            div_cnt_r <= 8'h00;
            div_act_r <= div_r;
            SCK       <= ~SCK;
            edge_r    <= edge_r + 4'd1;
            if (edge_r[0] == cpha_r) begin
              rx_sh_r <= {rx_sh_r[6:0], MISO};
            end else if (cpha_r) begin
              MOSI <= sh_r[7];
              sh_r <= {sh_r[6:0], 1'b0};
            end else if (edge_r != 4'd15) begin
              MOSI <= sh_r[6];
              sh_r <= {sh_r[6:0], 1'b0};
            end
            if (edge_r == 4'd15) begin
              state_r <= DONE;
            end
          end else begin
            div_cnt_r <= div_cnt_r + 8'd1;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m68k_spi_master_ctrl.sv
// Self-checking bench for m68k_spi_master_ctrl: bus accesses with a read
// scoreboard, an SCK edge monitor and a small SPI slave model.
module tb_m68k_spi_master_ctrl;
  logic       Clk = 1'b0;
  logic       Reset_H = 1'b1;
  logic       Enable_H = 1'b0;
  logic [2:0] Address = 3'd0;
  logic       WE_L = 1'b1;
  logic [7:0] DataIn = 8'h00;
  logic [7:0] DataOut;
  logic       DTACK_L, IRQ_L, SCK, MOSI, MISO;
  logic [7:0] SS_L;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int sck_edges = 0;
  int slv_base = 0;
  int edge_t[$];
  int sl_e, sl_idx;
  logic [1:0] miso_sel = 2'd0;
  logic       slv_cpha = 1'b0;
  logic [7:0] slv_tx = 8'hC3;
  logic [7:0] slv_rx = 8'h00;
  logic       slv_miso;
  logic [7:0] exp_q[$];
  string      tag_q[$];

  m68k_spi_master_ctrl #(.FIFO_DEPTH(4), .NUM_SS(8)) dut (
    .Clk(Clk), .Reset_H(Reset_H), .Enable_H(Enable_H), .Address(Address),
    .WE_L(WE_L), .DataIn(DataIn), .DataOut(DataOut), .DTACK_L(DTACK_L),
    .IRQ_L(IRQ_L), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .SS_L(SS_L)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Edge monitor; the slave samples MOSI on the master's sampling edges.
  always @(SCK) begin
    int e;
    sck_edges++;
    edge_t.push_back(cyc);
    e = sck_edges - slv_base;
    if (e >= 1 && e <= 16 && ((e % 2) == 1) == (slv_cpha == 1'b0))
      slv_rx = {slv_rx[6:0], MOSI};
  end

  // Slave output bit, MSB first, advanced on its launch edges.
  always_comb begin
    sl_e = sck_edges - slv_base;
    if (slv_cpha) sl_idx = (sl_e >= 1) ? (sl_e - 1) / 2 : 0;
    else          sl_idx = sl_e / 2;
    if (sl_idx > 7) sl_idx = 7;
    if (sl_idx < 0) sl_idx = 0;
    slv_miso = slv_tx[3'(7 - sl_idx)];
  end

  assign MISO = (miso_sel == 2'd0) ? MOSI : (miso_sel == 2'd1) ? 1'b0 : slv_miso;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic bus(input logic [2:0] a, input logic we_l, input logic [7:0] d,
                     input int hold, output logic [7:0] q);
    int low_cnt;
    low_cnt = 0;
    Address = a; WE_L = we_l; DataIn = d; Enable_H = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      if (DTACK_L == 1'b0) low_cnt++;
    end
    q = DataOut;
    Enable_H = 1'b0; WE_L = 1'b1;
    @(posedge Clk); #1;
    chk("dtack_low_cycles", low_cnt, hold);
    chk("dtack_release", DTACK_L, 1'b1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    logic [7:0] q;
    bus(a, 1'b0, d, 1, q);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] q, e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus(a, 1'b1, 8'h00, 2, q);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, q, e);
  endtask

  task automatic wait_edges(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((sck_edges - slv_base) < n && k < budget) begin
      @(posedge Clk); #1;
      k++;
    end
    chk(tag, sck_edges - slv_base, n);
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] tx;
    logic [1:0] m;

    // 1: reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_dataout", DataOut, 8'h00);
    chk("rst_dtack", DTACK_L, 1'b1);
    chk("rst_irq", IRQ_L, 1'b1);
    chk("rst_sck", SCK, 1'b0);
    chk("rst_mosi", MOSI, 1'b0);
    chk("rst_ss", SS_L, 8'hFF);
    Reset_H = 1'b0;
    rd(3'd1, 8'h05, "rst_stat");
    rd(3'd0, 8'h00, "rst_ctrl");
    rd(3'd3, 8'h00, "rst_div");
    rd(3'd4, 8'h00, "rst_ssel");
    rd(3'd5, 8'h00, "rsvd_5");

    // 2: long access pushes exactly once; then fill and overflow
    bus(3'd2, 1'b0, 8'hA5, 5, q);
    rd(3'd1, 8'h01, "one_push_stat");
    wr(3'd2, 8'h01); wr(3'd2, 8'h02); wr(3'd2, 8'h03);
    rd(3'd1, 8'h09, "tx_full_stat");
    wr(3'd2, 8'h04);
    rd(3'd1, 8'h49, "wcol_stat");

    // 5: four back-to-back transfers with MISO low, DIV=0
    miso_sel = 2'd1; slv_cpha = 1'b0;
    slv_base = sck_edges;
    wr(3'd0, 8'hC0);
    wait_edges(64, 600, "b2b_edges");
    repeat (60) @(posedge Clk);
    #1;
    chk("no_fifth_xfer", sck_edges - slv_base, 64);
    chk("b2b_span", edge_t[slv_base + 15] - edge_t[slv_base], 15);
    chk("b2b_gap", edge_t[slv_base + 16] - edge_t[slv_base + 15], 4);
    chk("irq_low", IRQ_L, 1'b0);
    rd(3'd1, 8'hC6, "rx_full_stat");
    wr(3'd1, 8'hC0);
    chk("irq_cleared", IRQ_L, 1'b1);
    rd(3'd1, 8'h06, "spif_wcol_clr");
    wr(3'd2, 8'h11);
    wait_edges(80, 300, "ovr_edges");
    repeat (5) @(posedge Clk);
    #1;
    rd(3'd1, 8'hA6, "rovr_stat");
    for (int i = 0; i < 4; i++) rd(3'd2, 8'h00, "rx_zero");
    rd(3'd1, 8'hA5, "rx_drained_stat");
    rd(3'd2, 8'h00, "rx_empty_read");
    wr(3'd1, 8'hE0);
    rd(3'd1, 8'h05, "stat_all_clr");

    // 3: mode 0 loopback with DIV=1
    wr(3'd0, 8'h00);
    wr(3'd3, 8'h01);
    miso_sel = 2'd0;
    slv_base = sck_edges;
    wr(3'd2, 8'h3C);
    wr(3'd0, 8'h40);
    wait_edges(16, 200, "m0_edges");
    repeat (5) @(posedge Clk);
    #1;
    chk("m0_span", edge_t[slv_base + 15] - edge_t[slv_base], 30);
    chk("m0_mosi", slv_rx, 8'h3C);
    rd(3'd1, 8'h84, "m0_stat_spif");
    rd(3'd2, 8'h3C, "m0_rx");
    rd(3'd1, 8'h85, "m0_stat_after");

    // 4: modes 1-3 against a slave returning 0xC3
    for (int md = 1; md < 4; md++) begin
      m = 2'(md);
      tx = 8'h5A ^ {6'h00, m} ^ {m, 6'h00};
      wr(3'd0, {4'h0, m, 2'b00});
      miso_sel = 2'd2; slv_cpha = m[0]; slv_tx = 8'hC3;
      slv_base = sck_edges;
      wr(3'd2, tx);
      wr(3'd0, {4'h4, m, 2'b00});
      wait_edges(16, 200, "mode_edges");
      repeat (5) @(posedge Clk);
      #1;
      chk("mode_mosi", slv_rx, tx);
      chk("mode_sck_idle", SCK, m[1]);
      rd(3'd2, 8'hC3, "mode_rx");
    end

    // 6: SPE cleared mid-transfer
    wr(3'd1, 8'hE0);
    wr(3'd0, 8'h08);
    wr(3'd3, 8'h03);
    miso_sel = 2'd0; slv_cpha = 1'b0;
    slv_base = sck_edges;
    wr(3'd2, 8'h77);
    wr(3'd0, 8'h48);
    wait_edges(7, 200, "abort_pre_edges");
    chk("abort_sck_low", SCK, 1'b0);
    wr(3'd0, 8'h08);
    chk("abort_sck_cpol", SCK, 1'b1);
    repeat (100) @(posedge Clk);
    #1;
    chk("abort_edges", sck_edges - slv_base, 8);
    rd(3'd1, 8'h05, "abort_stat");

    // slave select, then reset in the middle of an access
    wr(3'd4, 8'hA5);
    chk("ss_l", SS_L, 8'h5A);
    rd(3'd4, 8'hA5, "ssel_read");
    Address = 3'd3; WE_L = 1'b0; DataIn = 8'h33; Enable_H = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("dtack_mid", DTACK_L, 1'b0);
    Reset_H = 1'b1;
    @(posedge Clk); #1;
    chk("rst_mid_dtack", DTACK_L, 1'b1);
    chk("rst_mid_ss", SS_L, 8'hFF);
    chk("rst_mid_sck", SCK, 1'b0);
    Enable_H = 1'b0; WE_L = 1'b1;
    @(posedge Clk); #1;
    Reset_H = 1'b0;
    rd(3'd1, 8'h05, "rst_mid_stat");
    rd(3'd3, 8'h00, "rst_mid_div");
    rd(3'd0, 8'h00, "rst_mid_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
